// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU fetch definitions: widths, default parameters and fetch FSM states.
package fetch_sequencer_pkg;

   localparam int PC_W   = 12;
   localparam int INST_W = 16;
   localparam int BUF_W  = PC_W + INST_W;

   localparam logic [PC_W-1:0]   DEF_RESET_PC  = 12'h000;
   localparam logic [INST_W-1:0] DEF_HALT_WORD = 16'h0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction-memory read port, redirect strobe and instruction stream.
interface fetch_sequencer_if;
   import fetch_sequencer_pkg::*;

   logic [PC_W-1:0]   o_pc;
   logic              o_mem_en;
   logic [INST_W-1:0] i_mem_inst;
   logic              i_redirect;
   logic [PC_W-1:0]   i_redirect_pc;
   logic [INST_W-1:0] o_inst;
   logic [PC_W-1:0]   o_inst_pc;
   logic              o_inst_valid;
   logic              i_inst_ready;
   logic              o_halt;

   modport master (
      output o_pc, o_mem_en, o_inst, o_inst_pc, o_inst_valid, o_halt,
      input  i_mem_inst, i_redirect, i_redirect_pc, i_inst_ready
   );

   modport slave (
      input  o_pc, o_mem_en, o_inst, o_inst_pc, o_inst_valid, o_halt,
      output i_mem_inst, i_redirect, i_redirect_pc, i_inst_ready
   );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry instruction buffer holding {pc, inst}; flush empties it in one edge.
module fetch_buf
   import fetch_sequencer_pkg::*;
#(
   parameter int W = BUF_W
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_flush,
   input  logic         i_enq,
   input  logic [W-1:0] i_enq_data,
   input  logic         i_deq,
   output logic [W-1:0] o_head,
   output logic         o_valid,
   output logic [1:0]   o_count
);

   logic [W-1:0] slot [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         slot[0] <= '0;
         slot[1] <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
      end else if (i_flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (i_enq) begin
            slot[wr_ptr] <= i_enq_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (i_deq) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, i_enq} - {1'b0, i_deq};
      end
   end

   assign o_head  = slot[rd_ptr];
   assign o_valid = (count != 2'd0);
   assign o_count = count;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: keeps a 2-deep buffer topped up from a 1-cycle memory,
// handles redirects and stops on the HALT word.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [PC_W-1:0]   RESET_PC  = DEF_RESET_PC,
   parameter logic [INST_W-1:0] HALT_WORD = DEF_HALT_WORD
) (
   input  logic               i_clk,
   input  logic               i_reset,
   fetch_sequencer_if.master  bus
);

   fetch_state_t     state, state_nxt;
   logic [PC_W-1:0]  pc;
   logic [PC_W-1:0]  pc_p1;
   logic             vld_p1;
   logic             stale_p1;
   logic             live_p1;
   logic             mem_en;
   logic             enq;
   logic             deq;
   logic             halt_hit;
   logic [1:0]       count;
   logic [1:0]       occ;
   logic             buf_valid;
   logic [BUF_W-1:0] head;

   assign live_p1  = vld_p1 & ~stale_p1;
   assign deq      = buf_valid & bus.i_inst_ready;
   assign enq      = live_p1 & ~bus.i_redirect;
   assign halt_hit = enq & (bus.i_mem_inst == HALT_WORD);
   assign occ      = count + {1'b0, live_p1} - {1'b0, deq};

   always_comb begin
      state_nxt = state;
      mem_en    = 1'b0;
      case (state)
         IDLE: state_nxt = RUN;
         RUN: begin
            mem_en = (occ < 2'd2);
            if (halt_hit) state_nxt = HALT;
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
      if (bus.i_redirect) begin
         state_nxt = RUN;
         mem_en    = 1'b0;
      end
   end

   // issue stage -> response stage
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         vld_p1   <= 1'b0;
         stale_p1 <= 1'b0;
      end else begin
         state <= state_nxt;
         if (bus.i_redirect) begin
            pc       <= bus.i_redirect_pc;
            vld_p1   <= 1'b0;
            stale_p1 <= 1'b1;
         end else begin
            vld_p1 <= mem_en;
            // the read issued alongside the HALT word must never reach the buffer
            stale_p1 <= halt_hit;
            if (mem_en) pc <= pc + PC_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (mem_en) pc_p1 <= pc;
   end

   fetch_buf #(.W(BUF_W)) u_buf (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_flush    (bus.i_redirect),
      .i_enq      (enq),
      .i_enq_data ({pc_p1, bus.i_mem_inst}),
      .i_deq      (deq),
      .o_head     (head),
      .o_valid    (buf_valid),
      .o_count    (count)
   );

   assign bus.o_pc         = pc;
   assign bus.o_mem_en     = mem_en;
   assign bus.o_inst       = head[INST_W-1:0];
   assign bus.o_inst_pc    = head[BUF_W-1:INST_W];
   assign bus.o_inst_valid = buf_valid;
   assign bus.o_halt       = (state == HALT) && (count == 2'd0);

endmodule
